// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the command unit.
//   - arb_state_t                 : command credit arbiter FSM encoding
//   - NUM_REQ / REQ_*             : requester count and fixed requester slots
//   - CommandBufferLine           : one PSL command as buffered by a requester
//   - ResponseControlInterfaceOut : decoded PSL response (valid, tag, credits)
package cu_pkg;

  localparam int NUM_REQ     = 4;
  localparam int REQ_READ    = 0;
  localparam int REQ_WRITE   = 1;
  localparam int REQ_WED     = 2;
  localparam int REQ_RESTART = 3;

  localparam int               OUTSTANDING_W   = 9;
  localparam logic [8:0]       OUTSTANDING_MAX = 9'd256;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RUN      = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_ERROR    = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    logic [12:0] command;
    logic [63:0] address;
    logic [11:0] size;
    logic [7:0]  tag;
  } CommandBufferLine;

  typedef struct packed {
    logic       valid;
    logic [7:0] tag;
    logic [7:0] response_credits;
  } ResponseControlInterfaceOut;

endpackage

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: picks one of N requests, searching upward from a
// pointer that moves to one past the winner whenever advance is high.
//   clock, rst : clock and asynchronous active-high reset (pointer -> 0)
//   req        : request vector
//   advance    : the current grant was actually used; move the pointer
//   grant      : one-hot (or zero) combinational grant
module round_robin_arbiter #(
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_next;
  logic             found;
  int               idx;

  always_comb begin
    grant    = '0;
    found    = 1'b0;
    idx      = 0;
    ptr_next = ptr_q;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr_q) + off) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_next   = PTR_W'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= ptr_next;
    end
  end

endmodule

// File: rtl/cmd_credit_arbiter.sv
// cmd_credit_arbiter: issues at most one PSL command per cycle from NUM_REQ
// requesters, bounded by the command room captured at enable and by 256
// outstanding commands. The restart requester (highest index) always wins;
// the others share round-robin. Responses return credits and retire
// outstanding commands; any accounting inconsistency locks the block in
// ERROR until reset.
//   clock, rst      : clock and asynchronous active-high reset
//   enabled_in      : AFU enable; low returns to DISABLED and clears counters
//   croom_in        : command room, captured in LOAD
//   req_valid_in    : per-requester pending command, held until granted
//   req_cmd_in      : per-requester command fields
//   response_in     : decoded response (valid, tag, response_credits)
//   drain_in        : stop granting and wait for all responses
//   req_grant_out   : registered one-hot grant pulse
//   command_out     : registered issued command (valid, internal tag)
//   credits_out     : available credits
//   outstanding_out : commands issued without response
//   idle_out        : high in DISABLED
//   arb_error_out   : high in ERROR (sticky until reset)
module cmd_credit_arbiter
  import cu_pkg::*;
#(
  parameter int NUM_REQ  = cu_pkg::NUM_REQ,
  parameter int CREDIT_W = 8
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           enabled_in,
  input  logic [CREDIT_W-1:0]            croom_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  input  CommandBufferLine [NUM_REQ-1:0] req_cmd_in,
  input  ResponseControlInterfaceOut     response_in,
  input  logic                           drain_in,
  output logic [NUM_REQ-1:0]             req_grant_out,
  output CommandBufferLine               command_out,
  output logic [CREDIT_W-1:0]            credits_out,
  output logic [OUTSTANDING_W-1:0]       outstanding_out,
  output logic                           idle_out,
  output logic                           arb_error_out
);

  localparam int RR_N    = NUM_REQ - 1;
  localparam int RESTART = NUM_REQ - 1;
  // Two spare bits: one for underflow sign, one for response overshoot.
  localparam int CW      = CREDIT_W + 2;

  arb_state_t                 state_q, state_d;
  logic [CREDIT_W-1:0]        credits_q, croom_max_q;
  logic [OUTSTANDING_W-1:0]   outstanding_q, outstanding_next;
  logic [7:0]                 tag_q;
  logic [NUM_REQ-1:0]         valid_eff, grant_d;
  logic [RR_N-1:0]            rr_grant;
  logic                       rr_advance, issue, fire, resp_v, acct_active;
  logic                       over, acct_err;
  logic [CW-1:0]              credits_next;
  CommandBufferLine           cmd_d;
  logic                       resp_tag_unused;

  // Responses are matched by count only; the tag is not needed here.
  assign resp_tag_unused = ^response_in.tag;

  // A requester still shows valid in the cycle its grant is visible; mask it
  // so the same command is never granted twice.
  assign valid_eff = req_valid_in & ~req_grant_out;

  round_robin_arbiter #(.N(RR_N)) u_rr (
    .clock   (clock),
    .rst     (rst),
    .req     (valid_eff[RR_N-1:0]),
    .advance (rr_advance),
    .grant   (rr_grant)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    grant_d = '0;
    if (valid_eff[RESTART]) grant_d[RESTART] = 1'b1;
    else                    grant_d[RR_N-1:0] = rr_grant;

    cmd_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_d[i]) cmd_d = req_cmd_in[i];
    end
    cmd_d.valid = 1'b1;
    cmd_d.tag   = tag_q;

    resp_v      = response_in.valid;
    acct_active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    issue       = (state_q == ST_RUN) && enabled_in && !drain_in &&
                  (credits_q != '0) && (outstanding_q < OUTSTANDING_MAX) &&
                  (grant_d != '0);

    credits_next = {2'b00, credits_q} - CW'(issue) +
                   (resp_v ? CW'(response_in.response_credits) : CW'(0));
    over         = !credits_next[CW-1] && (credits_next > {2'b00, croom_max_q});
    acct_err     = acct_active &&
                   (credits_next[CW-1] || over || (resp_v && outstanding_q == '0));

    // The erroring cycle issues nothing.
    fire             = issue && !acct_err;
    rr_advance       = fire && !valid_eff[RESTART];
    outstanding_next = outstanding_q + OUTSTANDING_W'(fire) - OUTSTANDING_W'(resp_v);

    state_d = state_q;
    unique case (state_q)
      ST_DISABLED: if (enabled_in) state_d = ST_LOAD;
      ST_LOAD:     state_d = ST_RUN;
      ST_RUN:      if (drain_in) state_d = ST_DRAIN;
      ST_DRAIN:    if (outstanding_next == '0) state_d = ST_DISABLED;
      ST_ERROR:    state_d = ST_ERROR;
      default:     state_d = ST_DISABLED;
    endcase
    // Disable beats everything but ERROR; an accounting error beats the
    // normal transitions.
    if (state_q != ST_ERROR) begin
      if (!enabled_in)   state_d = ST_DISABLED;
      else if (acct_err) state_d = ST_ERROR;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q       <= ST_DISABLED;
      credits_q     <= '0;
      croom_max_q   <= '0;
      outstanding_q <= '0;
      tag_q         <= '0;
      req_grant_out <= '0;
      command_out   <= '0;
    end else begin
      // NOTE: registers use non-blocking assignment so every flop samples
      // the pre-edge values computed above, independent of statement order.
      state_q       <= state_d;
      req_grant_out <= fire ? grant_d : '0;
      command_out   <= fire ? cmd_d : '0;
      if (state_d == ST_DISABLED) begin
        credits_q     <= '0;
        croom_max_q   <= '0;
        outstanding_q <= '0;
        tag_q         <= '0;
      end else begin
        if (state_q == ST_LOAD) begin
          credits_q   <= croom_in;
          croom_max_q <= croom_in;
        end else if (acct_active && !acct_err) begin
          credits_q     <= credits_next[CREDIT_W-1:0];
          outstanding_q <= outstanding_next;
        end
        if (fire) tag_q <= tag_q + 8'd1;
      end
    end
  end

  assign credits_out     = credits_q;
  assign outstanding_out = outstanding_q;
  assign idle_out        = (state_q == ST_DISABLED);
  assign arb_error_out   = (state_q == ST_ERROR);

endmodule

// File: tb/tb_cmd_credit_arbiter.sv
// Directed bench for cmd_credit_arbiter: priority/round-robin order, credit
// return, tag wrap with outstanding limit, drain, error lock and reset.
module tb_cmd_credit_arbiter;
  import cu_pkg::*;

  logic                       clock = 1'b0;
  logic                       rst;
  logic                       enabled_in;
  logic [7:0]                 croom_in;
  logic [3:0]                 req_valid_in;
  CommandBufferLine [3:0]     req_cmd_in;
  ResponseControlInterfaceOut response_in;
  logic                       drain_in;
  logic [3:0]                 req_grant_out;
  CommandBufferLine           command_out;
  logic [7:0]                 credits_out;
  logic [8:0]                 outstanding_out;
  logic                       idle_out;
  logic                       arb_error_out;

  int checks = 0;
  int errors = 0;

  cmd_credit_arbiter dut (
    .clock           (clock),
    .rst             (rst),
    .enabled_in      (enabled_in),
    .croom_in        (croom_in),
    .req_valid_in    (req_valid_in),
    .req_cmd_in      (req_cmd_in),
    .response_in     (response_in),
    .drain_in        (drain_in),
    .req_grant_out   (req_grant_out),
    .command_out     (command_out),
    .credits_out     (credits_out),
    .outstanding_out (outstanding_out),
    .idle_out        (idle_out),
    .arb_error_out   (arb_error_out)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    enabled_in   = 1'b0;
    drain_in     = 1'b0;
    croom_in     = '0;
    req_valid_in = '0;
    response_in  = '0;
    for (int i = 0; i < 4; i++) begin
      req_cmd_in[i]         = '0;
      req_cmd_in[i].command = 13'h10 + 13'(i);
      req_cmd_in[i].address = 64'h1000 + 64'(i);
      req_cmd_in[i].size    = 12'(i + 1);
      req_cmd_in[i].tag     = 8'hEE;
    end
    repeat (2) @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (idle_out !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle_out); end
    checks++; if (req_grant_out !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0000", req_grant_out); end
    checks++; if (command_out !== '0) begin errors++; $display("FAIL reset_cmd: got %h expected 0", command_out); end
    checks++; if (credits_out !== 8'd0 || outstanding_out !== 9'd0) begin errors++; $display("FAIL reset_counters: got credits %0d outstanding %0d expected 0 0", credits_out, outstanding_out); end
    checks++; if (arb_error_out !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", arb_error_out); end
    step();
    checks++; if (idle_out !== 1'b1) begin errors++; $display("FAIL reset_stay_idle: got %b expected 1", idle_out); end
  endtask

  // croom 4, all four valid: restart first, then 0,1,2; credits run out.
  task automatic test_grant_order();
    logic [3:0] exp_grant [4];
    int         exp_idx   [4];
    exp_grant = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    exp_idx   = '{3, 0, 1, 2};
    do_reset();
    croom_in     = 8'd4;
    enabled_in   = 1'b1;
    req_valid_in = 4'b1111;
    step();
    checks++; if (idle_out !== 1'b0 || req_grant_out !== 4'b0) begin errors++; $display("FAIL order_load: got idle %b grant %b expected 0 0000", idle_out, req_grant_out); end
    step();
    checks++; if (credits_out !== 8'd4) begin errors++; $display("FAIL order_credits_loaded: got %0d expected 4", credits_out); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (req_grant_out !== exp_grant[k]) begin errors++; $display("FAIL order_grant[%0d]: got %b expected %b", k, req_grant_out, exp_grant[k]); end
      checks++; if (command_out.valid !== 1'b1 || command_out.tag !== 8'(k)) begin errors++; $display("FAIL order_tag[%0d]: got valid %b tag %0d expected 1 %0d", k, command_out.valid, command_out.tag, k); end
      checks++; if (command_out.address !== 64'h1000 + 64'(exp_idx[k]) || command_out.size !== 12'(exp_idx[k] + 1)) begin errors++; $display("FAIL order_fields[%0d]: got addr %h size %0d expected %h %0d", k, command_out.address, command_out.size, 64'h1000 + 64'(exp_idx[k]), exp_idx[k] + 1); end
      checks++; if (credits_out !== 8'(3 - k) || outstanding_out !== 9'(k + 1)) begin errors++; $display("FAIL order_acct[%0d]: got credits %0d outstanding %0d expected %0d %0d", k, credits_out, outstanding_out, 3 - k, k + 1); end
      req_valid_in = req_valid_in & ~req_grant_out;
    end
    req_valid_in = 4'b0001;
    step();
    checks++; if (req_grant_out !== 4'b0 || command_out.valid !== 1'b0) begin errors++; $display("FAIL order_no_credit: got grant %b valid %b expected 0000 0", req_grant_out, command_out.valid); end
    checks++; if (credits_out !== 8'd0 || outstanding_out !== 9'd4) begin errors++; $display("FAIL order_final_acct: got credits %0d outstanding %0d expected 0 4", credits_out, outstanding_out); end
  endtask

  // Continues from test_grant_order: credits 0, outstanding 4, req 0 pending.
  task automatic test_credit_return();
    response_in = '{valid: 1'b1, tag: 8'd0, response_credits: 8'd1};
    step();
    checks++; if (req_grant_out !== 4'b0 || credits_out !== 8'd1 || outstanding_out !== 9'd3) begin errors++; $display("FAIL credit_return: got grant %b credits %0d outstanding %0d expected 0000 1 3", req_grant_out, credits_out, outstanding_out); end
    step();
    checks++; if (req_grant_out !== 4'b0001 || command_out.tag !== 8'd4) begin errors++; $display("FAIL credit_grant: got grant %b tag %0d expected 0001 4", req_grant_out, command_out.tag); end
    checks++; if (credits_out !== 8'd1 || outstanding_out !== 9'd3) begin errors++; $display("FAIL credit_coincident: got credits %0d outstanding %0d expected 1 3", credits_out, outstanding_out); end
    response_in  = '0;
    req_valid_in = (req_valid_in & ~req_grant_out) | 4'b0010;
    step();
    checks++; if (req_grant_out !== 4'b0010 || command_out.tag !== 8'd5) begin errors++; $display("FAIL credit_rr_next: got grant %b tag %0d expected 0010 5", req_grant_out, command_out.tag); end
    checks++; if (credits_out !== 8'd0 || outstanding_out !== 9'd4) begin errors++; $display("FAIL credit_after: got credits %0d outstanding %0d expected 0 4", credits_out, outstanding_out); end
    req_valid_in = '0;
  endtask

  // 255 credits plus one response returning 3: 257 issues, tag wraps, and
  // the stall comes from outstanding=256 while one credit remains.
  task automatic test_tag_wrap();
    logic [7:0] exp_tag = 8'd0;
    int         count = 0;
    int         quiet = 0;
    bit         injected = 1'b0;
    do_reset();
    croom_in     = 8'd255;
    enabled_in   = 1'b1;
    req_valid_in = 4'b0011;
    step();
    step();
    for (int cyc = 0; cyc < 400 && quiet < 4; cyc++) begin
      step();
      response_in = '0;
      if (req_grant_out != 4'b0) begin
        quiet = 0;
        checks++; if (command_out.tag !== exp_tag) begin errors++; $display("FAIL wrap_tag[%0d]: got %0d expected %0d", count, command_out.tag, exp_tag); end
        exp_tag = exp_tag + 8'd1;
        count++;
        if (count == 200 && !injected) begin
          response_in = '{valid: 1'b1, tag: 8'd0, response_credits: 8'd3};
          injected    = 1'b1;
        end
      end else begin
        quiet++;
      end
    end
    checks++; if (count != 257) begin errors++; $display("FAIL wrap_count: got %0d expected 257", count); end
    checks++; if (outstanding_out !== 9'd256 || credits_out !== 8'd1) begin errors++; $display("FAIL wrap_stall: got outstanding %0d credits %0d expected 256 1", outstanding_out, credits_out); end
    checks++; if (req_grant_out !== 4'b0 || arb_error_out !== 1'b0) begin errors++; $display("FAIL wrap_quiet: got grant %b error %b expected 0000 0", req_grant_out, arb_error_out); end
  endtask

  task automatic test_drain();
    do_reset();
    croom_in     = 8'd4;
    enabled_in   = 1'b1;
    req_valid_in = 4'b0111;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      req_valid_in = req_valid_in & ~req_grant_out;
    end
    checks++; if (outstanding_out !== 9'd3 || credits_out !== 8'd1) begin errors++; $display("FAIL drain_setup: got outstanding %0d credits %0d expected 3 1", outstanding_out, credits_out); end
    drain_in     = 1'b1;
    req_valid_in = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (req_grant_out !== 4'b0 || idle_out !== 1'b0) begin errors++; $display("FAIL drain_hold[%0d]: got grant %b idle %b expected 0000 0", k, req_grant_out, idle_out); end
    end
    for (int r = 0; r < 3; r++) begin
      response_in = '{valid: 1'b1, tag: 8'(r), response_credits: 8'd1};
      step();
      response_in = '0;
      checks++; if (req_grant_out !== 4'b0) begin errors++; $display("FAIL drain_grant[%0d]: got %b expected 0000", r, req_grant_out); end
      if (r < 2) begin
        checks++; if (idle_out !== 1'b0 || outstanding_out !== 9'(2 - r) || credits_out !== 8'(2 + r)) begin errors++; $display("FAIL drain_resp[%0d]: got idle %b outstanding %0d credits %0d expected 0 %0d %0d", r, idle_out, outstanding_out, credits_out, 2 - r, 2 + r); end
        step();
      end else begin
        checks++; if (idle_out !== 1'b1 || outstanding_out !== 9'd0 || credits_out !== 8'd0) begin errors++; $display("FAIL drain_done: got idle %b outstanding %0d credits %0d expected 1 0 0", idle_out, outstanding_out, credits_out); end
      end
    end
    drain_in = 1'b0;
  endtask

  task automatic test_error();
    do_reset();
    croom_in   = 8'd2;
    enabled_in = 1'b1;
    step();
    step();
    checks++; if (credits_out !== 8'd2) begin errors++; $display("FAIL err_loaded: got %0d expected 2", credits_out); end
    response_in = '{valid: 1'b1, tag: 8'd0, response_credits: 8'd1};
    step();
    response_in  = '0;
    req_valid_in = 4'b1111;
    checks++; if (arb_error_out !== 1'b1 || req_grant_out !== 4'b0) begin errors++; $display("FAIL err_set: got error %b grant %b expected 1 0000", arb_error_out, req_grant_out); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (req_grant_out !== 4'b0 || arb_error_out !== 1'b1) begin errors++; $display("FAIL err_hold[%0d]: got grant %b error %b expected 0000 1", k, req_grant_out, arb_error_out); end
    end
    enabled_in = 1'b0;
    step();
    checks++; if (arb_error_out !== 1'b1 || idle_out !== 1'b0) begin errors++; $display("FAIL err_sticky: got error %b idle %b expected 1 0", arb_error_out, idle_out); end
    do_reset();
    checks++; if (arb_error_out !== 1'b0 || idle_out !== 1'b1) begin errors++; $display("FAIL err_cleared: got error %b idle %b expected 0 1", arb_error_out, idle_out); end
  endtask

  task automatic test_disable();
    do_reset();
    croom_in     = 8'd4;
    enabled_in   = 1'b1;
    req_valid_in = 4'b0001;
    step();
    step();
    step();
    checks++; if (req_grant_out !== 4'b0001 || credits_out !== 8'd3) begin errors++; $display("FAIL dis_setup: got grant %b credits %0d expected 0001 3", req_grant_out, credits_out); end
    enabled_in   = 1'b0;
    req_valid_in = 4'b0010;
    step();
    checks++; if (req_grant_out !== 4'b0 || idle_out !== 1'b1) begin errors++; $display("FAIL dis_no_grant: got grant %b idle %b expected 0000 1", req_grant_out, idle_out); end
    checks++; if (credits_out !== 8'd0 || outstanding_out !== 9'd0) begin errors++; $display("FAIL dis_cleared: got credits %0d outstanding %0d expected 0 0", credits_out, outstanding_out); end
  endtask

  task automatic test_reset_mid();
    int count = 0;
    do_reset();
    croom_in     = 8'd8;
    enabled_in   = 1'b1;
    req_valid_in = 4'b0011;
    step();
    step();
    for (int cyc = 0; cyc < 20 && count < 5; cyc++) begin
      step();
      if (req_grant_out != 4'b0) count++;
      if (count == 5) req_valid_in = '0;
    end
    checks++; if (outstanding_out !== 9'd5 || credits_out !== 8'd3) begin errors++; $display("FAIL mid_setup: got outstanding %0d credits %0d expected 5 3", outstanding_out, credits_out); end
    req_valid_in = 4'b0011;
    #2 rst = 1'b1;
    #1;
    checks++; if (req_grant_out !== 4'b0 || command_out !== '0) begin errors++; $display("FAIL mid_async_out: got grant %b cmd %h expected 0000 0", req_grant_out, command_out); end
    checks++; if (credits_out !== 8'd0 || outstanding_out !== 9'd0 || arb_error_out !== 1'b0 || idle_out !== 1'b1) begin errors++; $display("FAIL mid_async_state: got credits %0d outstanding %0d error %b idle %b expected 0 0 0 1", credits_out, outstanding_out, arb_error_out, idle_out); end
    @(negedge clock);
    rst = 1'b0;
    step();
    checks++; if (req_grant_out !== 4'b0 || command_out.valid !== 1'b0 || idle_out !== 1'b0) begin errors++; $display("FAIL mid_after_release: got grant %b valid %b idle %b expected 0000 0 0", req_grant_out, command_out.valid, idle_out); end
  endtask

  initial begin
    test_reset();
    test_grant_order();
    test_credit_return();
    test_tag_wrap();
    test_drain();
    test_error();
    test_disable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
